mem_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory port (req/addr_ok/data_ok) between the instruction-fetch requester (read only) and the MEM-stage data requester (read/write).
- One transaction is outstanding at a time.
- Data has fixed priority, with a starvation counter that guarantees instruction progress.
- Sits between the IF/MEM stages and the memory-side bridge.

---
 rtl/mem_bus_arbiter_pkg.sv | 33 +++
 rtl/mem_bus_arbiter_arb_pick.sv | 69 ++++++
 rtl/mem_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and default widths for the memory-bus arbiter.
//               It holds the FSM state encoding, the grant encoding and the
//               default parameter values. There are no ports.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  // Wide enough for STARVE_MAX up to 15.
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_I  = 3'd1,
    ST_REQ_D  = 3'd2,
    ST_WAIT_I = 3'd3,
    ST_WAIT_D = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Priority and starvation decision for the memory-bus arbiter.
//               Data wins over instruction fetch unless the fetch has lost
//               STARVE_MAX consecutive grant decisions. The starvation counter
//               is updated only when decide_i marks a grant decision.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               inst_req_i     - instruction request pending
//               data_req_i     - data request pending
//               decide_i       - this cycle is a grant decision point
//               pick_o         - combinational winner (NONE if no request)
// Revision    : 1.0 - initial release
// ============================================================================
import mem_bus_pkg::*;

module arb_pick #(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   inst_req_i,
  input  logic   data_req_i,
  input  logic   decide_i,
  output grant_t pick_o
);

  localparam logic [STARVE_CNT_W-1:0] C_STARVE_MAX = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] starve_cnt_q;
  logic [STARVE_CNT_W-1:0] starve_cnt_d;
  logic                    w_starved;

  assign w_starved = (starve_cnt_q == C_STARVE_MAX);

  always_comb begin
    pick_o = GNT_NONE;
    if (inst_req_i && (!data_req_i || w_starved)) begin
      pick_o = GNT_INST;
    end else if (data_req_i) begin
      pick_o = GNT_DATA;
    end
  end

  // The count only means something while a fetch is waiting, so any decision
  // taken with inst_req low (or that serves the fetch) starts it over.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (decide_i) begin
      if (pick_o == GNT_DATA && inst_req_i) begin
        if (!w_starved) begin
          starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one SRAM-like memory port (req/addr_ok/data_ok)
//               between the instruction-fetch requester (read only) and the
//               MEM-stage data requester (read/write). One transaction is
//               outstanding at a time. Data has fixed priority, and a
//               starvation counter guarantees fetch progress.
// Ports       : clk, rst                      - clock, sync active-high reset
//               inst_req/addr                 - fetch request
//               inst_addr_ok/data_ok/rdata    - fetch handshake / response
//               data_req/wr/wstrb/addr/wdata  - load/store request
//               data_addr_ok/data_ok/rdata    - data handshake / response
//               mem_req/wr/wstrb/addr/wdata   - downstream request
//               mem_addr_ok/data_ok/rdata     - downstream handshake / data
// Options     : MEM_BUS_ARB_STATS_EN adds the inst_grant_cnt, data_grant_cnt
//               and inst_stall_cnt outputs, each a 32-bit wrapping counter.
// Revision    : 1.0 - initial release
// ============================================================================
import mem_bus_pkg::*;

module mem_bus_arbiter #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef MEM_BUS_ARB_STATS_EN
  ,
  output logic [31:0]           inst_grant_cnt,
  output logic [31:0]           data_grant_cnt,
  output logic [31:0]           inst_stall_cnt
`endif
);

  state_t state_q;
  state_t state_d;
  grant_t grant_q;
  grant_t grant_d;
  grant_t w_pick;
  logic   w_decide;

  // A grant decision is taken whenever the bus is free: while idle, and in
  // the response cycle of the current transaction so that the next request
  // goes out with no bubble.
  always_comb begin
    w_decide = 1'b0;
    case (state_q)
      ST_IDLE:              w_decide = 1'b1;
      ST_WAIT_I, ST_WAIT_D: w_decide = mem_data_ok;
      default:              w_decide = 1'b0;
    endcase
  end

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb_pick (
    .clk        (clk),
    .rst        (rst),
    .inst_req_i (inst_req),
    .data_req_i (data_req),
    .decide_i   (w_decide),
    .pick_o     (w_pick)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    if (w_decide) begin
      grant_d = w_pick;
      case (w_pick)
        GNT_INST: state_d = ST_REQ_I;
        GNT_DATA: state_d = ST_REQ_D;
        default:  state_d = ST_IDLE;
      endcase
    end else begin
      // mem_data_ok outside WAIT never reaches here as a decision, so a
      // stray response in REQ leaves the state untouched.
      case (state_q)
        ST_REQ_I: if (mem_addr_ok) state_d = ST_WAIT_I;
        ST_REQ_D: if (mem_addr_ok) state_d = ST_WAIT_D;
        default:  state_d = state_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_wstrb    = '0;
    mem_addr     = inst_addr;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;

    if (grant_q == GNT_DATA) begin
      mem_wr    = data_wr;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end

    case (state_q)
      ST_REQ_I: begin
        mem_req      = 1'b1;
        inst_addr_ok = mem_addr_ok;
      end
      ST_REQ_D: begin
        mem_req      = 1'b1;
        data_addr_ok = mem_addr_ok;
      end
      ST_WAIT_I: inst_data_ok = mem_data_ok;
      ST_WAIT_D: data_data_ok = mem_data_ok;
      default: begin
      end
    endcase
  end

`ifdef MEM_BUS_ARB_STATS_EN
  logic [31:0] inst_grant_cnt_q;
  logic [31:0] data_grant_cnt_q;
  logic [31:0] inst_stall_cnt_q;
  logic        w_inst_grant;
  logic        w_data_grant;
  logic        w_inst_stall;

  assign w_inst_grant = w_decide && (w_pick == GNT_INST);
  assign w_data_grant = w_decide && (w_pick == GNT_DATA);
  // The fetch counts as served both in the cycle it is chosen and while its
  // request is on the bus.
  assign w_inst_stall = inst_req && !w_inst_grant && (state_q != ST_REQ_I);

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_grant_cnt_q <= '0;
      data_grant_cnt_q <= '0;
      inst_stall_cnt_q <= '0;
    end else begin
      if (w_inst_grant) inst_grant_cnt_q <= inst_grant_cnt_q + 32'd1;
      if (w_data_grant) data_grant_cnt_q <= data_grant_cnt_q + 32'd1;
      if (w_inst_stall) inst_stall_cnt_q <= inst_stall_cnt_q + 32'd1;
    end
  end

  assign inst_grant_cnt = inst_grant_cnt_q;
  assign data_grant_cnt = data_grant_cnt_q;
  assign inst_stall_cnt = inst_stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Two requester models
//               and a memory model with variable latency drive the DUT; a
//               transaction-level reference tracks bus ownership and
//               starvation and feeds scoreboard queues that a monitor checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int STARVE = 4;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_WAIT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_addr_ok, inst_data_ok;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic          wr;
    logic [SW-1:0] wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic own_d;
    req_t r;
  } txn_t;

  typedef struct packed {
    logic          own_d;
    logic          wr;
    logic [DW-1:0] rdata;
  } rsp_t;

  int checks = 0;
  int errors = 0;

  // Stimulus state
  req_t iq[$];
  req_t dq[$];
  req_t i_cur, d_cur;
  bit   i_act, d_act;
  int   inst_pct = 100, data_pct = 100;
  int   alat_min = 0, alat_max = 0, dlat_min = 1, dlat_max = 1;
  logic [DW-1:0] rq_fix[$];
  bit   stray_req, stray_now;

  // Memory model
  bit            m_busy, m_wait_set;
  int            m_acnt, m_dcnt;
  logic [DW-1:0] m_rdata, m_next_rdata;
  bit            ev_i_acc, ev_d_acc, ev_m_acc;

  // Reference model and scoreboards
  int   ph;
  bit   own_d;
  int   starve;
  txn_t txq[$];
  rsp_t rsq[$];
  bit   glog[$];
  int   n_idok, n_ddok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Arbitration rule applied to whatever the bench is currently requesting.
  task automatic model_decide();
    txn_t t;
    t = '0;
    if (inst_req && (!data_req || starve == STARVE)) begin
      own_d  = 1'b0;
      starve = 0;
      t.own_d = 1'b0;
      t.r.addr = inst_addr;
      txq.push_back(t);
      ph = P_REQ;
    end else if (data_req) begin
      own_d  = 1'b1;
      starve = inst_req ? ((starve < STARVE) ? starve + 1 : starve) : 0;
      t.own_d   = 1'b1;
      t.r.wr    = data_wr;
      t.r.wstrb = data_wstrb;
      t.r.addr  = data_addr;
      t.r.wdata = data_wdata;
      txq.push_back(t);
      ph = P_REQ;
    end else begin
      ph = P_IDLE;
    end
  endtask

  // Monitor + reference model, sampled mid-cycle.
  always @(negedge clk) begin
    txn_t t;
    rsp_t rs;
    if (rst) begin
      ph = P_IDLE;
      starve = 0;
      txq.delete();
      rsq.delete();
    end else begin
      chk("mem_req", 32'(mem_req), 32'(ph == P_REQ));
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(ph == P_REQ && !own_d && mem_addr_ok));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(ph == P_REQ && own_d && mem_addr_ok));
      if (inst_req && inst_addr_ok) ev_i_acc = 1'b1;
      if (data_req && data_addr_ok) ev_d_acc = 1'b1;

      if (mem_req && mem_addr_ok) begin
        glog.push_back(data_addr_ok);
        ev_m_acc = 1'b1;
        if (txq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_accept actual=unexpected required=no_transaction @%0t", $time);
          m_next_rdata = $urandom;
        end else begin
          t = txq.pop_front();
          chk("mem_addr", mem_addr, t.r.addr);
          chk("mem_wr", 32'(mem_wr), 32'(t.r.wr));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(t.r.wstrb));
          if (t.r.wr) chk("mem_wdata", mem_wdata, t.r.wdata);
          rs.own_d = t.own_d;
          rs.wr    = t.r.wr;
          rs.rdata = (rq_fix.size() > 0) ? rq_fix.pop_front() : $urandom;
          rsq.push_back(rs);
          m_next_rdata = rs.rdata;
        end
      end

      if (inst_data_ok) n_idok++;
      if (data_data_ok) n_ddok++;
      if (inst_data_ok || data_data_ok) begin
        if (rsq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_data_ok actual inst=%0d data=%0d required none @%0t",
                   inst_data_ok, data_data_ok, $time);
        end else begin
          rs = rsq.pop_front();
          chk("rsp_single", 32'(inst_data_ok & data_data_ok), 32'd0);
          chk("rsp_owner", 32'(data_data_ok), 32'(rs.own_d));
          if (!rs.own_d) chk("inst_rdata", inst_rdata, rs.rdata);
          else if (!rs.wr) chk("data_rdata", data_rdata, rs.rdata);
        end
      end

      case (ph)
        P_IDLE: model_decide();
        P_REQ:  if (mem_addr_ok) ph = P_WAIT;
        P_WAIT: begin
          if (mem_data_ok) begin
            chk("data_ok_forwarded", 32'(own_d ? data_data_ok : inst_data_ok), 32'd1);
            model_decide();
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic drive_cycle();
    if (rst) begin
      inst_req = 1'b0; data_req = 1'b0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      i_act = 1'b0; d_act = 1'b0; m_busy = 1'b0; m_wait_set = 1'b0;
      ev_i_acc = 1'b0; ev_d_acc = 1'b0; ev_m_acc = 1'b0;
      return;
    end
    if (ev_i_acc) i_act = 1'b0;
    if (ev_d_acc) d_act = 1'b0;
    ev_i_acc = 1'b0;
    ev_d_acc = 1'b0;
    if (!i_act && iq.size() > 0 && $urandom_range(99) < inst_pct) begin
      i_cur = iq.pop_front();
      i_act = 1'b1;
    end
    if (!d_act && dq.size() > 0 && $urandom_range(99) < data_pct) begin
      d_cur = dq.pop_front();
      d_act = 1'b1;
    end
    inst_req   = i_act;
    inst_addr  = i_cur.addr;
    data_req   = d_act;
    data_wr    = d_cur.wr;
    data_wstrb = d_cur.wstrb;
    data_addr  = d_cur.addr;
    data_wdata = d_cur.wdata;

    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (ev_m_acc) begin
      ev_m_acc   = 1'b0;
      m_busy     = 1'b1;
      m_wait_set = 1'b0;
      m_dcnt     = $urandom_range(dlat_max, dlat_min);
      m_rdata    = m_next_rdata;
    end
    if (m_busy) begin
      m_dcnt--;
      if (m_dcnt <= 0) begin
        mem_data_ok = 1'b1;
        mem_rdata   = m_rdata;
        m_busy      = 1'b0;
      end
    end else if (mem_req) begin
      if (!m_wait_set) begin
        m_acnt     = $urandom_range(alat_max, alat_min);
        m_wait_set = 1'b1;
      end
      if (m_acnt == 0) begin
        mem_addr_ok = 1'b1;
        m_wait_set  = 1'b0;
      end else begin
        m_acnt--;
      end
      if (stray_req && !mem_addr_ok) begin
        mem_data_ok = 1'b1;
        mem_rdata   = $urandom;
        stray_req   = 1'b0;
      end
    end else begin
      m_wait_set = 1'b0;
    end
    if (stray_now) begin
      mem_data_ok = 1'b1;
      mem_rdata   = $urandom;
      stray_now   = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      drive_cycle();
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_inst_addr_ok"}, 32'(inst_addr_ok), 32'd0);
    chk({tag, "_data_addr_ok"}, 32'(data_addr_ok), 32'd0);
    chk({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'd0);
    chk({tag, "_data_data_ok"}, 32'(data_data_ok), 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    repeat (n - 1) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (n < maxc && !(iq.size() == 0 && dq.size() == 0 && !i_act && !d_act &&
                         ph == P_IDLE && !m_busy)) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL wait_idle actual=%0d cycles required below %0d", n, maxc);
    end
    repeat (3) @(posedge clk);
  endtask

  function automatic req_t mk(input bit wr, input logic [SW-1:0] ws,
                              input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_t r;
    r.wr = wr; r.wstrb = ws; r.addr = a; r.wdata = wd;
    return r;
  endfunction

  initial begin
    int  base_i, base_d, n;
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    i_cur = '0; d_cur = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("init");
    @(posedge clk);
    #2 rst = 1'b0;

    // Fetch only, fixed latencies and read data.
    base_i = n_idok; base_d = n_ddok;
    alat_min = 2; alat_max = 2; dlat_min = 3; dlat_max = 3;
    rq_fix.push_back(32'h0280_0000);
    @(negedge clk);
    iq.push_back(mk(1'b0, '0, 32'h1C00_0000, '0));
    wait_idle(100);
    chk("t1_inst_data_ok_count", 32'(n_idok - base_i), 32'd1);
    chk("t1_data_data_ok_count", 32'(n_ddok - base_d), 32'd0);

    // Simultaneous requests: store goes first, fetch follows with no gap.
    glog.delete();
    alat_min = 1; alat_max = 1; dlat_min = 2; dlat_max = 2;
    @(negedge clk);
    dq.push_back(mk(1'b1, 4'b0011, 32'h0000_0100, 32'h0000_BEEF));
    iq.push_back(mk(1'b0, '0, 32'h1C00_0004, '0));
    wait_idle(100);
    chk("t2_grant_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("t2_first_is_data", 32'(glog[0]), 32'd1);
      chk("t2_second_is_inst", 32'(glog[1]), 32'd0);
    end

    // Starvation: both held busy -> DDDDI DDDDI.
    glog.delete();
    alat_min = 0; alat_max = 1; dlat_min = 1; dlat_max = 2;
    @(negedge clk);
    for (int k = 0; k < 8; k++) dq.push_back(mk(1'b0, '0, 32'h2000 + 32'(k * 4), '0));
    for (int k = 0; k < 2; k++) iq.push_back(mk(1'b0, '0, 32'h1C00_1000 + 32'(k * 4), '0));
    wait_idle(300);
    chk("t3_grant_count", 32'(glog.size()), 32'd10);
    for (int k = 0; k < 10 && k < glog.size(); k++) begin
      chk($sformatf("t3_grant_%0d", k), 32'(glog[k]), (k % 5 == 4) ? 32'd0 : 32'd1);
    end

    // Stray response while the data request is still waiting for addr_ok.
    base_d = n_ddok;
    alat_min = 3; alat_max = 3; dlat_min = 2; dlat_max = 2;
    stray_req = 1'b1;
    @(negedge clk);
    dq.push_back(mk(1'b0, '0, 32'h0000_0300, '0));
    wait_idle(100);
    chk("t4_stray_consumed", 32'(stray_req), 32'd0);
    chk("t4_data_data_ok_count", 32'(n_ddok - base_d), 32'd1);

    // Reset while waiting for fetch data, then a late stray response.
    alat_min = 0; alat_max = 0; dlat_min = 8; dlat_max = 8;
    @(negedge clk);
    iq.push_back(mk(1'b0, '0, 32'h1C00_2000, '0));
    n = 0;
    while (n < 50 && !(ph == P_WAIT && !own_d)) begin
      @(posedge clk);
      n++;
    end
    chk("t5_reached_wait", 32'(n < 50), 32'd1);
    base_i = n_idok;
    do_reset(2);
    @(posedge clk);
    #2 stray_now = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_stray_mem_data_ok_seen", 32'(mem_data_ok), 32'd1);
    chk("t5_no_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("t5_mem_req_low", 32'(mem_req), 32'd0);
    repeat (3) @(posedge clk);
    chk("t5_inst_data_ok_count", 32'(n_idok - base_i), 32'd0);
    dlat_min = 1; dlat_max = 3;
    @(negedge clk);
    iq.push_back(mk(1'b0, '0, 32'h1C00_3000, '0));
    wait_idle(100);
    chk("t5_recovered_count", 32'(n_idok - base_i), 32'd1);

    // Randomised traffic.
    base_i = n_idok; base_d = n_ddok;
    inst_pct = 50; data_pct = 50;
    alat_min = 0; alat_max = 2; dlat_min = 1; dlat_max = 3;
    @(negedge clk);
    for (int k = 0; k < 120; k++) begin
      iq.push_back(mk(1'b0, '0, $urandom & 32'hFFFF_FFFC, '0));
      dq.push_back(mk(1'($urandom_range(1)), 4'($urandom), $urandom & 32'hFFFF_FFFC, $urandom));
    end
    wait_idle(5000);
    chk("rand_inst_responses", 32'(n_idok - base_i), 32'd120);
    chk("rand_data_responses", 32'(n_ddok - base_d), 32'd120);
    chk("final_rsp_queue_empty", 32'(rsq.size()), 32'd0);
    chk("final_txn_queue_empty", 32'(txq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
